// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes and FSM state type.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WRITE,
        ST_RESP
    } lsu_state_t;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic for the LSU: store merge into the fetched word and load extract/extend.
// Halves use only offset[1] and words ignore the offset, so misaligned requests align down.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] merged_o,
    output logic [31:0] load_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        merged_o = word_i;
        case (funct3_i)
            F3_B: begin
                case (offset_i)
                    2'd0: merged_o[7:0]   = wdata_i[7:0];
                    2'd1: merged_o[15:8]  = wdata_i[7:0];
                    2'd2: merged_o[23:16] = wdata_i[7:0];
                    2'd3: merged_o[31:24] = wdata_i[7:0];
                endcase
            end
            F3_H: begin
                if (offset_i[1]) merged_o[31:16] = wdata_i[15:0];
                else             merged_o[15:0]  = wdata_i[15:0];
            end
            F3_W:    merged_o = wdata_i;
            default: merged_o = word_i;
        endcase
    end

    always_comb begin
        case (offset_i)
            2'd0: byte_sel = word_i[7:0];
            2'd1: byte_sel = word_i[15:8];
            2'd2: byte_sel = word_i[23:16];
            2'd3: byte_sel = word_i[31:24];
        endcase
        half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
        load_o   = '0;
        case (funct3_i)
            F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_o = {24'b0, byte_sel};
            F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_o = {16'b0, half_sel};
            F3_W:    load_o = word_i;
            default: load_o = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: FSM and registers between the execute stage and a word-wide memory.
// Build option LSU_MISALIGN_TRAP_EN: misaligned half/word accesses error instead of aligning down.
//
// state     | meaning
// ST_IDLE   | ready for a request; errored requests go straight to ST_RESP
// ST_ACCESS | read the addressed word into word_q; loads capture their result
// ST_WRITE  | write back the merged word (sub-word stores are read-modify-write)
// ST_RESP   | one-cycle response pulse
module lsu
    import lsu_pkg::*;
#(
    parameter int MEM_ADDR_BITS = 14
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_error_o,
    output logic [31:0] mem_address_o,
    output logic [31:0] mem_data_in_o,
    input  logic [31:0] mem_data_out_i,
    output logic        mem_we_o
);

    lsu_state_t  state_q, state_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_error_q;

    logic        hs;
    logic        misalign;
    logic        req_err;
    logic [31:0] align_word;
    logic [31:0] merged;
    logic [31:0] load_data;

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        case (req_funct3_i)
            F3_H, F3_HU: misalign = req_addr_i[0];
            F3_W:        misalign = |req_addr_i[1:0];
            default:     misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    assign hs      = req_valid_i && req_ready_o;
    assign req_err = (|req_addr_i[31:MEM_ADDR_BITS]) || !f3_legal(req_we_i, req_funct3_i) || misalign;

    // Loads extract straight from memory in ACCESS; stores merge into the captured word in WRITE.
    assign align_word = (state_q == ST_ACCESS) ? mem_data_out_i : word_q;

    lsu_align u_align (
        .funct3_i (f3_q),
        .offset_i (addr_q[1:0]),
        .word_i   (align_word),
        .wdata_i  (wdata_q),
        .merged_o (merged),
        .load_o   (load_data)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (hs) state_d = req_err ? ST_RESP : ST_ACCESS;
            ST_ACCESS: state_d = we_q ? ST_WRITE : ST_RESP;
            ST_WRITE:  state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o   = (state_q == ST_IDLE);
        rsp_valid_o   = (state_q == ST_RESP) && !reset_i;
        rsp_rdata_o   = reset_i ? '0 : rsp_rdata_q;
        rsp_error_o   = !reset_i && rsp_error_q;
        mem_address_o = '0;
        mem_data_in_o = '0;
        mem_we_o      = 1'b0;
        if (state_q == ST_ACCESS || state_q == ST_WRITE) begin
            mem_address_o = {addr_q[31:2], 2'b00};
        end
        if (state_q == ST_WRITE) begin
            mem_data_in_o = merged;
            mem_we_o      = !reset_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            we_q        <= 1'b0;
            f3_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            word_q      <= '0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hs) begin
                        we_q    <= req_we_i;
                        f3_q    <= req_funct3_i;
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        if (req_err) begin
                            rsp_rdata_q <= '0;
                            rsp_error_q <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    word_q <= mem_data_out_i;
                    if (!we_q) begin
                        rsp_rdata_q <= load_data;
                        rsp_error_q <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    rsp_rdata_q <= '0;
                    rsp_error_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus random loads/stores against a byte-array model.
module tb_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_we;

    logic [31:0] mem [0:4095];
    logic        pre_we;
    logic [11:0] pre_a;
    logic [31:0] pre_v;
    logic [7:0]  ref_b [0:16383];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lsu #(.MEM_ADDR_BITS(14)) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_funct3_i   (req_funct3),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .rsp_valid_o    (rsp_valid),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_error_o    (rsp_error),
        .mem_address_o  (mem_address),
        .mem_data_in_o  (mem_data_in),
        .mem_data_out_i (mem_data_out),
        .mem_we_o       (mem_we)
    );

    assign mem_data_out = mem[mem_address[13:2]];

    always @(posedge clk) begin
        if (mem_we)      mem[mem_address[13:2]] <= mem_data_in;
        else if (pre_we) mem[pre_a] <= pre_v;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_b[{a[13:2], 2'b00} + 14'(i)];
        return w;
    endfunction

    // Called at a negedge while the unit is idle; returns at a negedge.
    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        pre_we = 1'b1;
        pre_a  = a[13:2];
        pre_v  = v;
        for (int i = 0; i < 4; i++) ref_b[{a[13:2], 2'b00} + 14'(i)] = v[8*i +: 8];
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int          size;
        int          lat;
        int          we_cnt;
        int          we_lat;
        logic        legal;
        logic        err;
        logic [31:0] ea;
        logic [31:0] exp_rd;
        logic [31:0] exp_word;

        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        err   = !legal || (addr >= 32'h4000);
        ea    = addr;
`ifdef LSU_MISALIGN_TRAP_EN
        if (legal && (addr % size) != 0) err = 1'b1;
`else
        ea = addr - (addr % size);
`endif
        exp_rd   = '0;
        exp_word = '0;
        if (!err && !we) begin
            for (int i = 0; i < size; i++) exp_rd |= 32'(ref_b[ea[13:0] + 14'(i)]) << (8 * i);
            if (!f3[2] && size < 4 && exp_rd[8*size-1]) exp_rd |= 32'hFFFF_FFFF << (8 * size);
        end
        if (!err && we) begin
            for (int i = 0; i < size; i++) ref_b[ea[13:0] + 14'(i)] = 8'(wd >> (8 * i));
            exp_word = ref_word(ea);
        end

        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat    = 0;
        we_cnt = 0;
        we_lat = 0;
        rd     = '0;
        er     = 1'b0;
        while (lat < 8) begin
            @(negedge clk);
            lat++;
            if (mem_we) begin
                we_cnt++;
                we_lat = lat;
                chk("write_data", mem_data_in, exp_word);
                chk("write_addr", mem_address, {ea[31:2], 2'b00});
            end
            if (rsp_valid) begin
                rd = rsp_rdata;
                er = rsp_error;
                break;
            end
        end
        chk("rsp_latency", 32'(lat), err ? 32'd1 : (we ? 32'd3 : 32'd2));
        chk("rsp_error", {31'b0, er}, {31'b0, err});
        chk("rsp_rdata", rd, exp_rd);
        chk("write_count", 32'(we_cnt), (we && !err) ? 32'd1 : 32'd0);
        if (we && !err) begin
            chk("write_cycle", 32'(we_lat), 32'd2);
            chk("mem_word", mem[ea[13:2]], exp_word);
        end
        @(negedge clk);
        chk("rsp_pulse_one", {31'b0, rsp_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] old;
        logic [31:0] a;

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
        pre_we     = 1'b0;
        pre_a      = '0;
        pre_v      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_error", {31'b0, rsp_error}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'b0, req_ready}, 32'd1);

        for (int w = 0; w < 64; w++) set_word(32'(w * 4), $urandom);

        set_word(32'h40, 32'h8081_7F22);
        do_req(1'b0, 3'b000, 32'h41, 32'h0, rd, er);
        chk("lb_41", rd, 32'h0000_007F);
        do_req(1'b0, 3'b000, 32'h43, 32'h0, rd, er);
        chk("lb_43", rd, 32'hFFFF_FF80);
        do_req(1'b0, 3'b100, 32'h43, 32'h0, rd, er);
        chk("lbu_43", rd, 32'h0000_0080);

        set_word(32'h40, 32'h1122_3344);
        do_req(1'b1, 3'b000, 32'h42, 32'h0000_00AA, rd, er);
        chk("sb_42_word", mem[16], 32'h11AA_3344);

        set_word(32'h44, 32'h0);
        do_req(1'b1, 3'b001, 32'h46, 32'h0000_BEEF, rd, er);
        chk("sh_46_word", mem[17], 32'hBEEF_0000);
        do_req(1'b0, 3'b001, 32'h46, 32'h0, rd, er);
        chk("lh_46", rd, 32'hFFFF_BEEF);

        set_word(32'h40, 32'h8081_7F22);
        do_req(1'b0, 3'b010, 32'h41, 32'h0, rd, er);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lw_41_err", {31'b0, er}, 32'd1);
`else
        chk("lw_41_err", {31'b0, er}, 32'd0);
        chk("lw_41_data", rd, 32'h8081_7F22);
`endif
        do_req(1'b0, 3'b011, 32'h40, 32'h0, rd, er);
        chk("f3_011_err", {31'b0, er}, 32'd1);
        do_req(1'b0, 3'b000, 32'h0001_0000, 32'h0, rd, er);
        chk("oor_err", {31'b0, er}, 32'd1);
        do_req(1'b1, 3'b010, 32'h0001_0000, 32'h1234_5678, rd, er);
        chk("oor_store_err", {31'b0, er}, 32'd1);

        // Reset asserted while an SB is in its write cycle.
        set_word(32'h48, 32'hCAFE_F00D);
        old        = 32'hCAFE_F00D;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h49;
        req_wdata  = 32'h55;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rstw_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rstw_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rstw_no_rsp", {31'b0, rsp_valid}, 32'd0);
            chk("rstw_ready", {31'b0, req_ready}, 32'd1);
            @(negedge clk);
        end
        chk("rstw_mem_kept", mem[18], old);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 15) == 0) a = $urandom | 32'h0000_4000;
            else                            a = 32'($urandom_range(0, 255));
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, rd, er);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the core's execute stage and the word-wide `memory` block. It accepts one RV32I load or store per request, drives the memory's word address, data and write-enable, and returns the load data or store completion to the core. Loads are byte-lane extracted and then sign- or zero-extended. Sub-word stores are done as read-modify-write, because `memory` only has a whole-word write enable.

## Interface
- `MEM_ADDR_BITS`, default 14: byte-address bits backed by memory. A request with any `req_addr[31:MEM_ADDR_BITS]` bit set is out of range.
- `clk` in 1: the single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: the core has a request.
- `req_ready` out 1: the unit can accept a request; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3 of the load or store.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data; right-justified for SB/SH.
- `rsp_valid` out 1: one-cycle pulse marking completion.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_error` out 1: the request was misaligned, out of range, or had an illegal funct3.
- `mem_address` out 32: to `memory.address`.
- `mem_data_in` out 32: to `memory.data_in`.
- `mem_data_out` in 32: from `memory.data_out`; combinational read.
- `mem_we` out 1: to `memory.we`.

## Operation
- FSM states: IDLE, ACCESS, WRITE, RESP.
- **IDLE**
  - A handshake is `req_valid && req_ready`. On a handshake, latch we, funct3, addr and wdata.
  - If the request is an error, go to RESP. Otherwise go to ACCESS.
- **ACCESS**
  - Drive `mem_address = {addr_q[31:2],2'b00}` and capture `mem_data_out` into `word_q`.
  - Loads go to RESP. Stores go to WRITE.
- **WRITE**
  - Drive the same `mem_address`. Set `mem_we = !reset`.
  - Drive `mem_data_in` = `word_q` with the selected lanes replaced:
    - SB replaces byte `addr_q[1:0]`.
    - SH replaces half `addr_q[1]`.
    - SW replaces the whole word.
  - Go to RESP.
- **RESP**
  - `rsp_valid = 1` for exactly one cycle; the core must take it. Go to IDLE.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - All other values are illegal and raise `rsp_error`.
- Load extraction: select the byte or half by `addr_q[1:0]`. LB and LH sign-extend from bit 7 or bit 15. LBU and LHU zero-extend.
- An errored request never enters ACCESS or WRITE, and memory is untouched.
- Outside ACCESS and WRITE, `mem_address`, `mem_data_in` and `mem_we` are all 0.

## Timing
- A handshake in cycle T gives:
  - load: `rsp_valid` at T+2;
  - store: memory written at the edge ending T+2, `rsp_valid` at T+3;
  - error: `rsp_valid` at T+1.
- Throughput: `req_ready` rises again in the cycle after RESP.
- Values while `reset` is high and in the cycle after it:
  - state is IDLE;
  - `rsp_valid`, `rsp_error` and `rsp_rdata` are 0;
  - `mem_we` is 0;
  - `req_ready` is 1 from the first cycle after reset deasserts.
- Reset during WRITE: `mem_we` is gated low, so no partial write occurs. Reset in ACCESS or RESP drops the request with no response.
- Response registers hold their value until the next RESP. `rsp_valid` alone qualifies them.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - LH/LHU/SH with `addr[0]` = 1 is an error.
  - LW/SW with `addr[1:0]` ≠ 0 is an error.
- Not defined:
  - Misaligned addresses are silently aligned down to the access size: `addr[0]` is cleared for halves, `addr[1:0]` for words.
  - The access proceeds normally and no error is raised.
- Out-of-range and illegal-funct3 errors apply in both builds.

## Structure
- `lsu_pkg`: funct3 localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`) and the state enum `lsu_state_t`.
- Sub-module `lsu_align`: combinational store-merge and load-extract/extend, given funct3, `addr[1:0]`, the word and the wdata. The top level contains the FSM and registers only.

## Test plan
- Memory word 0x40 = 0x8081_7F22; LB at 0x41 → `rsp_rdata` 0x0000_007F at T+2. LB at 0x43 → 0xFFFF_FF80. LBU at 0x43 → 0x0000_0080.
- SB 0xAA at 0x42 onto word 0x1122_3344 → `mem_we` at T+2 only, `mem_data_in` 0x11AA_3344, `rsp_valid` at T+3.
- SH 0xBEEF at 0x46 onto 0x0000_0000 → word 0xBEEF_0000. A following LH at 0x46 → 0xFFFF_BEEF.
- LW at 0x41:
  - with `LSU_MISALIGN_TRAP_EN` → `rsp_error` 1 at T+1, no memory access;
  - without it → data of word 0x40, `rsp_error` 0.
- Load with funct3 = 011, or with `req_addr` 0x0001_0000 (MEM_ADDR_BITS = 14) → `rsp_error` 1 at T+1, `mem_we` never asserts.
- Assert `reset` during the WRITE cycle of an SB → `mem_we` stays 0, memory is unchanged, no `rsp_valid`, and `req_ready` is 1 after reset.
